// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch PC unit: opcode field, opcode codes, FSM encodings.
package fetch_pc_unit_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int OPCODE_MSB     = 24;
    localparam int OPCODE_LSB     = 22;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_LW   = 3'd2,
        OP_SW   = 3'd3,
        OP_BEQ  = 3'd4,
        OP_JALR = 3'd5,
        OP_HALT = 3'd6,
        OP_NOOP = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [2:0] get_opcode(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus between the PC unit, instruction memory and the hazard/branch logic.
// FETCH_PERF_EN adds the fetch_count performance counter signal.
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 16
);
    logic              stall;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic [31:0]       imem_instr;
    logic [31:0]       pc;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_pc;
    logic              halted;
`ifdef FETCH_PERF_EN
    logic [31:0]       fetch_count;
`endif

    modport master (
        input  stall,
        input  redir_valid,
        input  redir_pc,
        input  imem_instr,
        output pc,
        output instr_valid,
        output instr_pc,
        output halted
`ifdef FETCH_PERF_EN
        , output fetch_count
`endif
    );

    modport slave (
        output stall,
        output redir_valid,
        output redir_pc,
        output imem_instr,
        input  pc,
        input  instr_valid,
        input  instr_pc,
        input  halted
`ifdef FETCH_PERF_EN
        , input  fetch_count
`endif
    );
endinterface

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Combinational next-state selector for the fetch PC unit.
// Priority inside FETCH: redirect > halt > stall > increment.
module fetch_pc_unit_pc_next_sel
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        HALT_OP  = OP_HALT
) (
    input  fetch_state_e      state_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] instr_pc_i,
    input  logic              instr_valid_i,
    input  logic [31:0]       instr_i,
    input  logic              stall_i,
    input  logic              redir_valid_i,
    input  logic [ADDR_W-1:0] redir_pc_i,
    output fetch_state_e      state_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o
);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_i[31:OPCODE_MSB+1], instr_i[OPCODE_LSB-1:0]};

    always_comb begin
        state_o       = state_i;
        pc_o          = pc_i;
        instr_pc_o    = instr_pc_i;
        instr_valid_o = instr_valid_i;
        case (state_i)
            ST_BOOT: begin
                state_o       = ST_FETCH;
                pc_o          = RESET_PC + ADDR_W'(1);
                instr_pc_o    = RESET_PC;
                instr_valid_o = 1'b1;
            end
            ST_FETCH: begin
                if (redir_valid_i) begin
                    // Word already in flight belongs to the wrong path: squash it.
                    pc_o          = redir_pc_i;
                    instr_pc_o    = redir_pc_i;
                    instr_valid_o = 1'b0;
                end else if (instr_valid_i && get_opcode(instr_i) == HALT_OP) begin
                    state_o       = ST_HALTED;
                    instr_valid_o = 1'b0;
                end else if (!stall_i) begin
                    instr_pc_o    = pc_i;
                    pc_o          = pc_i + ADDR_W'(1);
                    instr_valid_o = 1'b1;
                end
            end
            ST_HALTED: begin
                instr_valid_o = 1'b0;
            end
            default: begin
                state_o       = ST_BOOT;
                pc_o          = RESET_PC;
                instr_pc_o    = RESET_PC;
                instr_valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter / fetch sequencer in front of a 1-cycle registered instruction memory.
// Define FETCH_PERF_EN to add the saturating fetch_count counter.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]        HALT_OP  = OP_HALT
) (
    input logic             clk,
    input logic             rst_n,
    fetch_pc_unit_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;

    fetch_pc_unit_pc_next_sel #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .HALT_OP  (HALT_OP)
    ) u_pc_next_sel (
        .state_i       (state_q),
        .pc_i          (pc_q),
        .instr_pc_i    (instr_pc_q),
        .instr_valid_i (instr_valid_q),
        .instr_i       (bus.imem_instr),
        .stall_i       (bus.stall),
        .redir_valid_i (bus.redir_valid),
        .redir_pc_i    (bus.redir_pc),
        .state_o       (state_d),
        .pc_o          (pc_d),
        .instr_pc_o    (instr_pc_d),
        .instr_valid_o (instr_valid_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.pc          = 32'(pc_q);
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    // Never valid while halted, so the count holds there without a special case.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (instr_valid_q && fetch_count_q != 32'hFFFF_FFFF) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: vector table plus hand-written reset/halt sequences.
// Also exercises a narrow ADDR_W=4 instance for PC wrap-around.
module tb_fetch_pc_unit;

    localparam logic [31:0] W_NOOP = 32'h01C0_0000;
    localparam logic [31:0] W_HALT = 32'h0180_0000;

    logic clk;
    logic rst_n;
    logic rst_n_w;

    fetch_pc_unit_if #(.ADDR_W(16)) bus ();
    fetch_pc_unit_if #(.ADDR_W(4))  bus_w ();

    fetch_pc_unit #(.ADDR_W(16), .RESET_PC(16'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_pc_unit #(.ADDR_W(4), .RESET_PC(4'd14)) dut_w (
        .clk   (clk),
        .rst_n (rst_n_w),
        .bus   (bus_w)
    );

    always #5 clk = ~clk;

    // Registered-read instruction memory that clears its output on reset.
    logic [31:0] mem [0:255];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.imem_instr <= '0;
        else        bus.imem_instr <= mem[bus.pc[7:0]];
    end
    assign bus_w.imem_instr = W_NOOP;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic [31:0] e_pc;
        logic [15:0] e_ipc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t tbl [28];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rp,
                                input logic [31:0] p, input logic [15:0] ip,
                                input logic v, input logic h);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp;
        t.e_pc = p; t.e_ipc = ip; t.e_valid = v; t.e_halted = h;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic [31:0] p, input logic [15:0] ip,
                              input logic v, input logic h);
        check({tag, " pc"},          bus.pc,                  p);
        check({tag, " instr_pc"},    {16'd0, bus.instr_pc},   {16'd0, ip});
        check({tag, " instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
        check({tag, " halted"},      {31'd0, bus.halted},     {31'd0, h});
        $display("%s: pc=%0h instr_pc=%0h valid=%0b halted=%0b", tag,
                 bus.pc, bus.instr_pc, bus.instr_valid, bus.halted);
    endtask

    logic [31:0] w_exp_pc  [3];
    logic [3:0]  w_exp_ipc [3];
    int          exp_cnt;

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        rst_n_w = 1'b0;
        n_vec = 0;
        n_err = 0;
        exp_cnt = 0;
        bus.stall = 1'b0; bus.redir_valid = 1'b0; bus.redir_pc = '0;
        bus_w.stall = 1'b0; bus_w.redir_valid = 1'b0; bus_w.redir_pc = '0;
        for (int i = 0; i < 256; i++) mem[i] = W_NOOP;
        mem[8'h30] = W_HALT;

        tbl[0]  = mk(0, 0, 16'h0000, 32'h1,     16'h0,    1, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 32'h2,     16'h1,    1, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 32'h3,     16'h2,    1, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 32'h4,     16'h3,    1, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 32'h5,     16'h4,    1, 0);
        tbl[5]  = mk(1, 0, 16'h0000, 32'h5,     16'h4,    1, 0);
        tbl[6]  = mk(1, 0, 16'h0000, 32'h5,     16'h4,    1, 0);
        tbl[7]  = mk(1, 0, 16'h0000, 32'h5,     16'h4,    1, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 32'h6,     16'h5,    1, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 32'h7,     16'h6,    1, 0);
        tbl[10] = mk(0, 1, 16'h0020, 32'h20,    16'h20,   0, 0);
        tbl[11] = mk(0, 0, 16'h0000, 32'h21,    16'h20,   1, 0);
        tbl[12] = mk(0, 0, 16'h0000, 32'h22,    16'h21,   1, 0);
        tbl[13] = mk(1, 1, 16'h0040, 32'h40,    16'h40,   0, 0);
        tbl[14] = mk(1, 0, 16'h0000, 32'h40,    16'h40,   0, 0);
        tbl[15] = mk(0, 0, 16'h0000, 32'h41,    16'h40,   1, 0);
        tbl[16] = mk(0, 1, 16'hFFFF, 32'hFFFF,  16'hFFFF, 0, 0);
        tbl[17] = mk(0, 0, 16'h0000, 32'h0,     16'hFFFF, 1, 0);
        tbl[18] = mk(0, 0, 16'h0000, 32'h1,     16'h0,    1, 0);
        tbl[19] = mk(0, 1, 16'h0030, 32'h30,    16'h30,   0, 0);
        tbl[20] = mk(0, 0, 16'h0000, 32'h31,    16'h30,   1, 0);
        tbl[21] = mk(0, 1, 16'h0010, 32'h10,    16'h10,   0, 0);
        tbl[22] = mk(0, 0, 16'h0000, 32'h11,    16'h10,   1, 0);
        tbl[23] = mk(0, 1, 16'h0030, 32'h30,    16'h30,   0, 0);
        tbl[24] = mk(0, 0, 16'h0000, 32'h31,    16'h30,   1, 0);
        tbl[25] = mk(1, 0, 16'h0000, 32'h31,    16'h30,   0, 1);
        tbl[26] = mk(0, 1, 16'h0005, 32'h31,    16'h30,   0, 1);
        tbl[27] = mk(1, 1, 16'h0008, 32'h31,    16'h30,   0, 1);

        w_exp_pc[0] = 32'd15; w_exp_pc[1] = 32'd0;  w_exp_pc[2] = 32'd1;
        w_exp_ipc[0] = 4'd14; w_exp_ipc[1] = 4'd15; w_exp_ipc[2] = 4'd0;

        repeat (2) @(negedge clk);
        check_main("reset", 32'h0, 16'h0, 1'b0, 1'b0);
        check("w reset pc", bus_w.pc, 32'd14);
`ifdef FETCH_PERF_EN
        check("reset fetch_count", bus.fetch_count, 32'd0);
`endif

        rst_n = 1'b1;
        rst_n_w = 1'b1;
        #1;
        check_main("boot", 32'h0, 16'h0, 1'b0, 1'b0);
        check("w boot pc", bus_w.pc, 32'd14);
        check("w boot valid", {31'd0, bus_w.instr_valid}, 32'd0);

        for (int i = 0; i < 28; i++) begin
            bus.stall       = tbl[i].stall;
            bus.redir_valid = tbl[i].redir;
            bus.redir_pc    = tbl[i].rpc;
            @(posedge clk);
            @(negedge clk);
            check_main($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ipc,
                       tbl[i].e_valid, tbl[i].e_halted);
            if (i < 3) begin
                check($sformatf("w vec%0d pc", i), bus_w.pc, w_exp_pc[i]);
                check($sformatf("w vec%0d instr_pc", i), {28'd0, bus_w.instr_pc}, {28'd0, w_exp_ipc[i]});
                check($sformatf("w vec%0d valid", i), {31'd0, bus_w.instr_valid}, 32'd1);
            end
`ifdef FETCH_PERF_EN
            check($sformatf("vec%0d fetch_count", i), bus.fetch_count, 32'(exp_cnt));
            exp_cnt += int'(tbl[i].e_valid);
`endif
        end
        bus.stall = 1'b0; bus.redir_valid = 1'b0; bus.redir_pc = '0;

        // Asynchronous reset out of HALTED, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 check_main("rst from halted", 32'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_main($sformatf("run%0d", k), 32'(k), 16'(k - 1), 1'b1, 1'b0);
        end

        // Mid-run reset at pc=9.
        #2 rst_n = 1'b0;
        #1 check_main("rst midrun", 32'h0, 16'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        check("rst midrun fetch_count", bus.fetch_count, 32'd0);
`endif
        mem[3] = W_HALT;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_main("boot2", 32'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_main($sformatf("halt_run%0d", k), 32'(k), 16'(k - 1), 1'b1, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        check_main("halted", 32'h4, 16'h3, 1'b0, 1'b1);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 16'h0077;
        for (int k = 0; k < 3; k++) begin
            bus.stall = k[0];
            @(posedge clk);
            @(negedge clk);
            check_main($sformatf("halt_hold%0d", k), 32'h4, 16'h3, 1'b0, 1'b1);
        end
`ifdef FETCH_PERF_EN
        check("halt fetch_count", bus.fetch_count, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
